// File: rtl/arduino_link_pkg.sv
// arduino_link_pkg: framing constants and FSM encoding shared by the GPIO link
// between the FPGA and the Arduino (arduino_tx_link outbound, arduino_fpga_comm inbound).
// No ports; imported with "import arduino_link_pkg::*;".
package arduino_link_pkg;

  // Default framing: 16-bit payload, 100 kbit/s at 50 MHz, 20 us inter-frame gap.
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_BIT_CYCLES = 500;
  localparam int DEF_GAP_CYCLES = 1000;

  // State encodings kept as plain constants so legacy code can compare raw bits.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } tx_state_t;

endpackage

// File: rtl/arduino_tx_link_fifo.sv
// tx_fifo: small synchronous FIFO buffering outbound words.
// Ports: clk, reset (async, active-high), push/push_data, pop/pop_data (head word,
// valid whenever not empty), count, full, empty. Pushes while full and pops while empty are ignored.
module tx_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // Full-check only uses the current count, so a simultaneous pop never frees a slot for a push.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arduino_tx_link.sv
// arduino_tx_link: buffers game-event words and serialises each one MSB first on
// tx_clk/tx_data/tx_frame (Arduino samples tx_data on tx_clk rising edges).
// Ports: clk, reset (async, active-high), wr_data/wr_valid/wr_ready write side,
// fifo_count, busy, frames_sent status, tx_clk/tx_data/tx_frame GPIO lines.
// Build option ARDUINO_TX_PARITY_EN appends an even-parity bit after the payload LSB.
module arduino_tx_link
  import arduino_link_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic [15:0]                   frames_sent,
  output logic                          tx_clk,
  output logic                          tx_data,
  output logic                          tx_frame
);

`ifdef ARDUINO_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = DATA_W + PAR_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int PH_W       = $clog2(BIT_CYCLES);
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam int HALF       = BIT_CYCLES / 2;

  tx_state_t              state;
  logic [FRAME_BITS-1:0]  shreg;
  logic [BIT_W-1:0]       bit_cnt;
  logic [PH_W-1:0]        phase;
  logic [GAP_W-1:0]       gap_cnt;
  logic [DATA_W-1:0]      head;
  logic [FRAME_BITS-1:0]  load_word;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;

  assign wr_ready = !fifo_full;
  assign busy     = (state != IDLE);
  assign pop      = (state == LOAD);

  // Parity travels as an extra LSB of the shift register so the shifter stays uniform.
`ifdef ARDUINO_TX_PARITY_EN
  assign load_word = {head, ^head};
`else
  assign load_word = head;
`endif

  tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      phase       <= '0;
      gap_cnt     <= '0;
      tx_clk      <= 1'b0;
      tx_data     <= 1'b0;
      tx_frame    <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= LOAD;
        end
        LOAD: begin
          shreg    <= load_word;
          bit_cnt  <= BIT_W'(FRAME_BITS - 1);
          phase    <= '0;
          tx_frame <= 1'b1;
          tx_clk   <= 1'b0;
          tx_data  <= load_word[FRAME_BITS-1];
          state    <= SHIFT;
        end
        SHIFT: begin
          if (phase == PH_W'(BIT_CYCLES - 1)) begin
            if (bit_cnt == '0) begin
              tx_frame    <= 1'b0;
              tx_clk      <= 1'b0;
              tx_data     <= 1'b0;
              gap_cnt     <= '0;
              frames_sent <= frames_sent + 16'd1;
              state       <= GAP;
            end else begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt - BIT_W'(1);
              phase   <= '0;
              tx_clk  <= 1'b0;
              tx_data <= shreg[FRAME_BITS-2];
            end
          end else begin
            phase  <= phase + PH_W'(1);
            // Registered, so decide on the phase about to be entered.
            tx_clk <= (phase >= PH_W'(HALF - 1));
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arduino_tx_link.sv
module tb_arduino_tx_link;

  localparam int DW = 16;
  localparam int FD = 4;
  localparam int BC = 4;
  localparam int GC = 6;
`ifdef ARDUINO_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB   = DW + PB;
  localparam int FLEN = FB * BC;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [2:0]    fifo_count;
  logic          busy;
  logic [15:0]   frames_sent;
  logic          tx_clk;
  logic          tx_data;
  logic          tx_frame;

  int checks = 0;
  int errors = 0;

  arduino_tx_link #(
    .DATA_W     (DW),
    .FIFO_DEPTH (FD),
    .BIT_CYCLES (BC),
    .GAP_CYCLES (GC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .frames_sent (frames_sent),
    .tx_clk      (tx_clk),
    .tx_data     (tx_data),
    .tx_frame    (tx_frame)
  );

  always #5 clk = ~clk;

  // Line monitor: frame lengths, inter-frame low runs, and bits sampled on tx_clk rises.
  int          high_run = 0;
  int          low_run = 0;
  int          nbits = 0;
  logic        prev_clk = 1'b0;
  logic [31:0] cur_word = '0;
  bit          ended_once = 1'b0;
  int          len_q[$];
  int          gap_q[$];
  int          nbits_q[$];
  logic [31:0] word_q[$];

  always @(negedge clk) begin
    if (tx_frame) begin
      if (high_run == 0) begin
        cur_word = '0;
        nbits = 0;
        if (ended_once) gap_q.push_back(low_run);
        low_run = 0;
      end
      high_run++;
    end else begin
      if (high_run > 0) begin
        len_q.push_back(high_run);
        word_q.push_back(cur_word);
        nbits_q.push_back(nbits);
        high_run = 0;
        ended_once = 1'b1;
        low_run = 0;
      end
      low_run++;
    end
    if (tx_clk && !prev_clk) begin
      cur_word = {cur_word[30:0], tx_data};
      nbits++;
    end
    prev_clk = tx_clk;
  end

  function automatic logic [15:0] payload(input logic [31:0] w);
    logic [31:0] t;
    t = w >> PB;
    return t[15:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w);
    wr_data = w;
    wr_valid = 1'b1;
    tick;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < 3000) begin
      tick;
      n++;
    end
    checks++;
    if (busy || fifo_count != 0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b fifo_count=%0d, required idle within 3000 cycles", nm, busy, fifo_count);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2 reset = 1'b1;
    #2;
    checks++;
    if ({tx_clk, tx_data, tx_frame} !== 3'b000) begin
      errors++; $display("FAIL reset_tx: got %b, required 000", {tx_clk, tx_data, tx_frame});
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_wr_ready: got %b, required 1", wr_ready);
    end
    checks++;
    if ({fifo_count, busy, frames_sent} !== 20'd0) begin
      errors++; $display("FAIL reset_status: count=%0d busy=%b frames=%0d, required all 0", fifo_count, busy, frames_sent);
    end
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    logic [15:0] fs0;
    fs0 = frames_sent;
    send(16'hA5C3);                       // accepted at edge N
    checks++;
    if (fifo_count !== 3'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_accept: count=%0d busy=%b, required 1 0", fifo_count, busy);
    end
    tick;                                 // edge N+1: LOAD
    checks++;
    if (busy !== 1'b1 || tx_frame !== 1'b0) begin
      errors++; $display("FAIL single_load: busy=%b frame=%b, required 1 0", busy, tx_frame);
    end
    tick;                                 // edge N+2: frame starts with MSB
    checks++;
    if ({tx_frame, tx_data, tx_clk} !== 3'b110 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL single_start: frame/data/clk=%b count=%0d, required 110 0", {tx_frame, tx_data, tx_clk}, fifo_count);
    end
    tick;
    tick;                                 // edge N+4: first tx_clk rise
    checks++;
    if (tx_clk !== 1'b1) begin
      errors++; $display("FAIL single_clk_rise: got %b, required 1", tx_clk);
    end
    wait_idle("single");
    checks++;
    if (len_q.size() == 0 || len_q[$] != FLEN || nbits_q[$] != FB) begin
      errors++; $display("FAIL single_len: frames=%0d, required length %0d with %0d bits", len_q.size(), FLEN, FB);
    end
    checks++;
    if (word_q.size() == 0 || payload(word_q[$]) !== 16'hA5C3) begin
      errors++; $display("FAIL single_bits: got %h, required a5c3", (word_q.size() == 0) ? 16'h0 : payload(word_q[$]));
    end
    checks++;
    if (frames_sent !== fs0 + 16'd1) begin
      errors++; $display("FAIL single_count: got %0d, required %0d", frames_sent, fs0 + 16'd1);
    end
  endtask

  task automatic test_push_pop;
    int t0;
    t0 = word_q.size();
    wr_valid = 1'b1;
    wr_data = 16'hBEEF; tick;             // N
    wr_data = 16'h0001; tick;             // N+1: two words held, entering LOAD
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++; $display("FAIL pp_two: count=%0d, required 2", fifo_count);
    end
    wr_data = 16'h8000; tick;             // N+2: push coincides with LOAD pop
    wr_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd2 || tx_frame !== 1'b1) begin
      errors++; $display("FAIL pp_same_cycle: count=%0d frame=%b, required 2 1", fifo_count, tx_frame);
    end
    wait_idle("push_pop");
    checks++;
    if (word_q.size() != t0 + 3 || payload(word_q[t0]) !== 16'hBEEF ||
        payload(word_q[t0+1]) !== 16'h0001 || payload(word_q[t0+2]) !== 16'h8000) begin
      errors++; $display("FAIL pp_order: %0d new frames, required beef 0001 8000 in order", word_q.size() - t0);
    end
  endtask

  task automatic test_fill;
    logic [15:0] w [6];
    int exp_cnt [6];
    int t0, g0;
    w = '{16'hC0DE, 16'h1357, 16'h2468, 16'h9ABC, 16'hFEED, 16'hDEAD};
    exp_cnt = '{1, 2, 2, 3, 4, 4};
    t0 = word_q.size();
    g0 = gap_q.size();
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = w[i];
      tick;
      checks++;
      if (fifo_count !== 3'(exp_cnt[i]) || wr_ready !== (exp_cnt[i] != 4)) begin
        errors++; $display("FAIL fill_step%0d: count=%0d ready=%b, required %0d %b", i, fifo_count, wr_ready, exp_cnt[i], exp_cnt[i] != 4);
      end
    end
    wr_valid = 1'b0;
    wait_idle("fill");
    checks++;
    if (word_q.size() != t0 + 5) begin
      errors++; $display("FAIL fill_frames: got %0d, required 5", word_q.size() - t0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (payload(word_q[t0+i]) !== w[i] || len_q[t0+i] != FLEN) begin
          errors++; $display("FAIL fill_word%0d: got %h len %0d, required %h len %0d", i, payload(word_q[t0+i]), len_q[t0+i], w[i], FLEN);
        end
      end
    end
    checks++;
    if (gap_q.size() != g0 + 5) begin
      errors++; $display("FAIL fill_gap_count: got %0d gaps, required 5", gap_q.size() - g0);
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (gap_q[g0+i] != GC + 2) begin
          errors++; $display("FAIL fill_gap%0d: got %0d low cycles, required %0d", i, gap_q[g0+i], GC + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    wr_valid = 1'b1;
    wr_data = 16'h1234; tick;             // N
    wr_data = 16'h5555; tick;             // N+1
    wr_valid = 1'b0;
    repeat (32) tick;                     // N+33: bit 7, phase 3
    checks++;
    if ({tx_frame, tx_clk} !== 2'b11 || fifo_count !== 3'd1) begin
      errors++; $display("FAIL rmid_before: frame/clk=%b count=%0d, required 11 1", {tx_frame, tx_clk}, fifo_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_frame, tx_clk, tx_data} !== 3'b000) begin
      errors++; $display("FAIL rmid_tx: got %b, required 000", {tx_frame, tx_clk, tx_data});
    end
    checks++;
    if (fifo_count !== 3'd0 || frames_sent !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_state: count=%0d frames=%0d busy=%b, required 0 0 0", fifo_count, frames_sent, busy);
    end
    tick;
    reset = 1'b0;
    tick;
    send(16'h0F0F);
    wait_idle("reset_mid");
    checks++;
    if (payload(word_q[$]) !== 16'h0F0F || len_q[$] != FLEN || frames_sent !== 16'd1) begin
      errors++; $display("FAIL rmid_after: got %h len %0d frames %0d, required 0f0f len %0d frames 1", payload(word_q[$]), len_q[$], frames_sent, FLEN);
    end
  endtask

  task automatic test_parity;
    send(16'h0007);
    wait_idle("parity7");
    checks++;
    if (payload(word_q[$]) !== 16'h0007 || len_q[$] != FLEN || nbits_q[$] != FB) begin
      errors++; $display("FAIL par7_frame: got %h len %0d bits %0d, required 0007 len %0d bits %0d", payload(word_q[$]), len_q[$], nbits_q[$], FLEN, FB);
    end
`ifdef ARDUINO_TX_PARITY_EN
    checks++;
    if (word_q[$][0] !== 1'b1) begin
      errors++; $display("FAIL par7_bit: got %b, required 1", word_q[$][0]);
    end
    send(16'h0003);
    wait_idle("parity3");
    checks++;
    if (word_q[$][0] !== 1'b0 || payload(word_q[$]) !== 16'h0003) begin
      errors++; $display("FAIL par3_bit: got %b payload %h, required 0 0003", word_q[$][0], payload(word_q[$]));
    end
`endif
  endtask

  task automatic test_wrap;
    force dut.frames_sent = 16'hFFFF;
    tick;
    release dut.frames_sent;
    send(16'h5A5A);
    wait_idle("wrap");
    checks++;
    if (frames_sent !== 16'd0) begin
      errors++; $display("FAIL wrap_count: got %0d, required 0", frames_sent);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_push_pop;
    test_fill;
    test_reset_mid;
    test_parity;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arduino_tx_link.md
Name: arduino_tx_link

Overview:
- FPGA-to-Arduino transmitter. It is the outbound direction of the GPIO link whose inbound side is arduino_fpga_comm (cursor X/Y from the Arduino).
- Takes game-event words from the NIOS side and buffers them in a small FIFO. Each word is serialised onto three GPIO header lines as a framed, clocked bit stream: tx_clk, tx_data and tx_frame.
- Example payloads: slice hits, streak, haptic pulse requests.
- Instantiated in VeggieVik beside arduino_fpga_comm; fed from a to_hw_port register.

Parameters:
- DATA_W, 16, payload bits per frame.
- FIFO_DEPTH, 4, buffered words; must be a power of two, 2 or more.
- BIT_CYCLES, 500, clk cycles per bit (100 kbit/s at 50 MHz); must be even, 4 or more.
- GAP_CYCLES, 1000, idle clk cycles forced between frames.

Ports:
- clk, in, 1, 50 MHz system clock.
- reset, in, 1, asynchronous, active-high.
- wr_data, in, DATA_W, word to send.
- wr_valid, in, 1, write request.
- wr_ready, out, 1, FIFO can accept a word.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, words buffered.
- busy, out, 1, high in any state other than IDLE.
- frames_sent, out, 16, count of completed frames; wraps.
- tx_clk, out, 1, serial clock to Arduino; Arduino samples on the rising edge.
- tx_data, out, 1, serial data, MSB first.
- tx_frame, out, 1, high for the whole frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: every output is 0 except wr_ready, which is 1. FIFO is empty, FSM is in IDLE.
- Reset asserted mid-frame: tx lines drop low immediately, FIFO contents are discarded, and the partial frame is not counted.
- FIFO push:
  - A push occurs when wr_valid && wr_ready at a rising edge.
  - wr_ready = (fifo_count != FIFO_DEPTH). It is combinational from the count only.
  - When full, writes are dropped even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle on a non-full FIFO leave the count unchanged. The pushed word is stored normally.
- FIFO pop: occurs only in the LOAD state. Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, SHIFT, GAP.
  - IDLE -> LOAD when fifo_count != 0.
  - LOAD (1 cycle): pop the head word into the shift register; bit counter = DATA_W-1; phase counter = 0; tx_frame <= 1; tx_data <= head MSB.
  - SHIFT:
    - The phase counter runs 0..BIT_CYCLES-1.
    - tx_clk is 0 for phases 0..BIT_CYCLES/2-1 and 1 for the rest.
    - At phase BIT_CYCLES-1: if the bit counter is 0, go to GAP. Otherwise shift left, decrement the bit counter and present the next bit on tx_data.
  - GAP: tx_frame, tx_clk and tx_data are all 0 for GAP_CYCLES cycles. frames_sent increments on the GAP entry edge. Then go to IDLE.
- Latency:
  - With the FIFO empty and the FSM in IDLE, a word accepted at edge N makes fifo_count = 1 after edge N.
  - LOAD is entered at edge N+1.
  - tx_frame rises and the first data bit appears at edge N+2.
  - The first tx_clk rising edge is BIT_CYCLES/2 cycles later.
- Frame length: tx_frame stays high for exactly DATA_W*BIT_CYCLES cycles (plus the parity bit if enabled).
- Back-to-back words: separated by exactly GAP_CYCLES+2 cycles of tx_frame low (GAP, then IDLE and LOAD).
- Output registering: all tx lines are registered; no combinational path from wr_* to tx_*.

Optional Feature:
- Macro: ARDUINO_TX_PARITY_EN.
- Defined: after the LSB, one extra bit period carries even parity (XOR of the payload) with the same tx_clk timing. tx_frame extends by BIT_CYCLES.
- Undefined: no parity bit; the frame is DATA_W bits.

Decomposition:
- Package arduino_link_pkg:
  - tx_state_t enum {IDLE, LOAD, SHIFT, GAP}.
  - Default constants: BIT_CYCLES, GAP_CYCLES, DATA_W.
  - Shared with arduino_fpga_comm for common framing constants.
- Sub-module tx_fifo: parameterised synchronous FIFO with push, pop, count and full/empty outputs.
- The FSM and serialiser stay in arduino_tx_link.

Test Plan (BIT_CYCLES=4, GAP_CYCLES=6, DATA_W=16):
- Single word: write 16'hA5C3 into an idle block -> tx_frame rises 2 cycles after acceptance, stays high 64 cycles, and the bits sampled on tx_clk rising edges read 1010010111000011; frames_sent becomes 1.
- Fill to full: write 6 words back-to-back while transmitting -> wr_ready goes low at fifo_count=4; the rejected word never appears on the line; 5 frames total (1 in flight + 4 buffered), each separated by 8 low cycles.
- Push and pop in the same cycle: FIFO holds 2 words, a write coincides with LOAD -> fifo_count stays 2; the order of transmitted words is preserved.
- Reset mid-frame: assert reset at bit 7 -> tx lines are 0 within the same cycle (asynchronous); fifo_count=0; frames_sent unchanged; the next write transmits a clean full frame.
- Parity (ARDUINO_TX_PARITY_EN): send 16'h0007 -> 17th bit = 1 and tx_frame is high 68 cycles. Send 16'h0003 -> 17th bit = 0.
- Counter wrap: preload frames_sent to 16'hFFFF via force, then send one frame -> frames_sent = 0.
